// File: rtl/counter_frame_pkg.sv
// Shared constants, slot-count helper and serializer state type for counter_frame_tx.
// COUNTER_FRAME_CHECKSUM_EN adds a trailing XOR checksum slot to every frame.
package counter_frame_pkg;

  localparam int TAG_W  = 3;
  localparam int PAY_W  = 5;
  localparam int SLOT_W = 8;
  localparam logic [TAG_W-1:0] CHK_TAG = 3'b111;

`ifdef COUNTER_FRAME_CHECKSUM_EN
  localparam int CHK_SLOTS = 1;
`else
  localparam int CHK_SLOTS = 0;
`endif

  typedef enum logic {IDLE, SEND} state_t;

  // ceil((cnt_w + 1) / PAY_W): counter bits plus the restart flag
  function automatic int num_slots(input int cnt_w);
    return (cnt_w + PAY_W) / PAY_W;
  endfunction

  function automatic int frame_w(input int cnt_w);
    return SLOT_W * (num_slots(cnt_w) + CHK_SLOTS);
  endfunction

endpackage

// File: rtl/counter_frame_tx_if.sv
// Byte-serial valid/ready link between the frame serializer and the board-side sink.
interface counter_frame_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/frame_serializer.sv
// Streams a captured frame MSB-slot-first over the byte link; owns slot index and FSM.
module frame_serializer
  import counter_frame_pkg::*;
#(
  parameter int TOTAL_SLOTS = 4,
  parameter int FRAME_W     = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load,
  input  logic [FRAME_W-1:0] frame_next,
  output logic               can_accept,
  output logic               busy,
  counter_frame_tx_if.master tx
);

  localparam int IDX_W = (TOTAL_SLOTS > 1) ? $clog2(TOTAL_SLOTS) : 1;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [FRAME_W-1:0] shift_q;
  logic               handshake;

  assign handshake  = tx.tx_valid && tx.tx_ready;
  // A new frame may load on the very cycle the last slot leaves, giving gapless frames
  assign can_accept = (state == IDLE) || (handshake && (idx == '0));
  assign tx.tx_data = shift_q[FRAME_W-1 -: SLOT_W];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      idx         <= '0;
      shift_q     <= '0;
      tx.tx_valid <= 1'b0;
      busy        <= 1'b0;
    end else if (load) begin
      state       <= SEND;
      idx         <= IDX_W'(TOTAL_SLOTS - 1);
      shift_q     <= frame_next;
      tx.tx_valid <= 1'b1;
      busy        <= 1'b1;
    end else if (handshake) begin
      if (idx == '0) begin
        state       <= IDLE;
        tx.tx_valid <= 1'b0;
        busy        <= 1'b0;
      end else begin
        idx     <= idx - IDX_W'(1);
        shift_q <= shift_q << SLOT_W;
      end
    end
  end

endmodule

// File: rtl/counter_frame_tx.sv
// Free-running up/down counter with snapshot capture into tagged 8-bit slots.
// Define COUNTER_FRAME_CHECKSUM_EN to append an XOR checksum slot to each frame.
module counter_frame_tx
  import counter_frame_pkg::*;
#(
  parameter int              CNT_W    = 16,
  parameter longint unsigned STEP     = 1,
  parameter int              SATURATE = 0
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      en,
  input  logic                      dir,
  input  logic                      clear,
  input  logic                      sample,
  output logic [CNT_W-1:0]          count,
  output logic                      wrap,
  output logic [frame_w(CNT_W)-1:0] frame_out,
  output logic                      frame_valid,
  counter_frame_tx_if.master        tx,
  output logic                      busy,
  output logic                      sample_drop
);

  localparam int NUM_SLOTS   = num_slots(CNT_W);
  localparam int TOTAL_SLOTS = NUM_SLOTS + CHK_SLOTS;
  localparam int FRAME_W     = frame_w(CNT_W);
  localparam int WORD_W      = PAY_W * NUM_SLOTS;
  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);
  localparam logic [CNT_W-1:0] MAX_C  = '1;

  logic               restart_flag;
  logic               can_accept;
  logic               accept;
  logic [CNT_W:0]     sum_up;
  logic [CNT_W:0]     sum_dn;
  logic [WORD_W-1:0]  word;
  logic [FRAME_W-1:0] frame_next;

  // The extra MSB is the carry/borrow that marks a wrap or a blocked clamp
  assign sum_up = {1'b0, count} + {1'b0, STEP_C};
  assign sum_dn = {1'b0, count} - {1'b0, STEP_C};
  assign accept = sample && can_accept;

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    word             = '0;
    word[CNT_W:0]    = {count, restart_flag};
    frame_next       = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      frame_next[SLOT_W*(k+CHK_SLOTS) +: SLOT_W] = {TAG_W'(k), word[PAY_W*k +: PAY_W]};
    end
`ifdef COUNTER_FRAME_CHECKSUM_EN
    begin
      logic [PAY_W-1:0] chk;
      chk = '0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        chk = chk ^ word[PAY_W*k +: PAY_W];
      end
      frame_next[SLOT_W-1:0] = {CHK_TAG, chk};
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count        <= '0;
      wrap         <= 1'b0;
      restart_flag <= 1'b1;
      frame_out    <= '0;
      frame_valid  <= 1'b0;
      sample_drop  <= 1'b0;
    end else begin
      if (clear) begin
        count <= '0;
        wrap  <= 1'b0;
      end else if (en) begin
        if (dir) begin
          if (sum_up[CNT_W]) count <= (SATURATE != 0) ? MAX_C : sum_up[CNT_W-1:0];
          else               count <= sum_up[CNT_W-1:0];
          wrap <= sum_up[CNT_W];
        end else begin
          if (sum_dn[CNT_W]) count <= (SATURATE != 0) ? '0 : sum_dn[CNT_W-1:0];
          else               count <= sum_dn[CNT_W-1:0];
          wrap <= sum_dn[CNT_W];
        end
      end else begin
        wrap <= 1'b0;
      end

      // clear outranks the capture's flag clear when both land together
      if (clear)       restart_flag <= 1'b1;
      else if (accept) restart_flag <= 1'b0;

      if (accept) frame_out <= frame_next;
      frame_valid <= accept;
      sample_drop <= sample && !can_accept;
    end
  end

  frame_serializer #(
    .TOTAL_SLOTS (TOTAL_SLOTS),
    .FRAME_W     (FRAME_W)
  ) u_serializer (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (accept),
    .frame_next (frame_next),
    .can_accept (can_accept),
    .busy       (busy),
    .tx         (tx)
  );

endmodule
